// File: rtl/nes_uart_controller.sv
// NES $4016/$4017 joypad port emulation fed by a UART button stream.
// Each received 8N1 byte becomes the button vector read back serially.
module baud_rate_gen #(
  parameter int BAUD_DIV = 326
) (
  input  logic clk,
  input  logic rst_n,
  output logic en
);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  assign en = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module nes_uart_controller #(
  parameter int BAUD_DIV   = 326,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       rw,
  input  logic       addr,
  inout  wire  [7:0] cpubus,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] rx_data_peek
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  logic en;

  baud_rate_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en)
  );

  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  rx_state_t state, state_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] buttons, buttons_n;
  logic wait_high, wait_high_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      buttons   <= '0;
      wait_high <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
      buttons   <= buttons_n;
      wait_high <= wait_high_n;
    end
  end

  always_comb begin
    state_n     = state;
    tick_n      = tick_cnt;
    bit_n       = bit_cnt;
    shreg_n     = shreg;
    buttons_n   = buttons;
    wait_high_n = wait_high;
    if (en) begin
      unique case (state)
        IDLE: begin
          // after a framing error the line must go idle before a new start
          if (wait_high) begin
            if (rx_s) wait_high_n = 1'b0;
          end else if (!rx_s) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          if (tick_cnt == T_HALF) begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == T_LAST) begin
            tick_n  = '0;
            shreg_n = {rx_s, shreg[7:1]};
            bit_n   = bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state_n = STOP;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == T_LAST) begin
            tick_n  = '0;
            state_n = IDLE;
            if (rx_s) begin
              buttons_n = shreg;
            end else begin
              wait_high_n = 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  logic wr0, rd0, rd1;
  logic strobe;
  logic rd_q;
  logic [7:0] shift;

  assign wr0 = !cs && !rw && !addr;
  assign rd0 = !cs && rw && !addr;
  assign rd1 = !cs && rw && addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe <= 1'b0;
      rd_q   <= 1'b0;
      shift  <= '0;
    end else begin
      rd_q <= rd0;
      if (wr0) strobe <= cpubus[0];
      // advance once per access, when the read select drops
      if (strobe) begin
        shift <= buttons;
      end else if (rd_q && !rd0) begin
        shift <= {1'b1, shift[7:1]};
      end
    end
  end

  assign cpubus = rd0 ? {7'b0, shift[0]} :
                  rd1 ? 8'h00 : 8'hzz;

  assign txd          = 1'b1;
  assign rx_data_peek = buttons;
endmodule

// File: tb/tb_nes_uart_controller.sv
// Directed bench for nes_uart_controller: UART receive, strobe/read,
// framing error, controller 2 and bus release.
module tb_nes_uart_controller;
  localparam int BD  = 20;
  localparam int OS  = 16;
  localparam int BIT = BD * OS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b1;
  logic rw = 1'b1;
  logic addr = 1'b0;
  logic rxd = 1'b1;
  logic txd;
  logic [7:0] rx_data_peek;
  logic drv_en = 1'b0;
  logic [7:0] drv = 8'h00;
  wire [7:0] cpubus;

  int checks = 0;
  int failures = 0;

  assign cpubus = drv_en ? drv : 8'hzz;

  // released bus reads all ones; the DUT never drives bits 7:1 high
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (cpubus[i]);
  end

  always #5 clk = ~clk;

  nes_uart_controller #(
    .BAUD_DIV  (BD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs          (cs),
    .rw          (rw),
    .addr        (addr),
    .cpubus      (cpubus),
    .rxd         (rxd),
    .txd         (txd),
    .rx_data_peek(rx_data_peek)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic bus_write(input logic a, input logic [7:0] v);
    @(negedge clk);
    cs = 1'b0;
    rw = 1'b0;
    addr = a;
    drv = v;
    drv_en = 1'b1;
    @(negedge clk);
    cs = 1'b1;
    rw = 1'b1;
    drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b0;
    rw = 1'b1;
    addr = a;
    #2;
    d = cpubus;
    @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
  endtask

  logic [7:0] d;
  logic [9:0] exp_a5;
  logic [8:0] exp_3c;
  int c, first, second;

  initial begin
    exp_a5 = 10'b11_1010_0101;
    exp_3c = 9'b1_0011_1100;

    repeat (10) @(negedge clk);
    #2;
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_peek", {24'b0, rx_data_peek}, 32'h00);
    check("rst_bus_z", {24'b0, cpubus}, 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    c = 0;
    first = -1;
    second = -1;
    while (second < 0 && c < 10 * BD) begin
      @(negedge clk);
      if (dut.en) begin
        if (first < 0) first = c;
        else second = c;
      end
      c++;
    end
    check("tick_spacing", second - first, BD);

    send_byte(8'hA5, 1'b1);
    check("rx_a5", {24'b0, rx_data_peek}, 32'hA5);

    @(negedge clk);
    rxd = 1'b0;
    repeat (3 * BD) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    check("glitch_ignored", {24'b0, rx_data_peek}, 32'hA5);

    bus_write(1'b0, 8'h01);
    bus_write(1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      bus_read(1'b0, d);
      check($sformatf("read_a5_%0d", i), {24'b0, d},
            {31'b0, exp_a5[i]});
    end

    bus_write(1'b0, 8'h01);
    for (int i = 0; i < 3; i++) begin
      bus_read(1'b0, d);
      check($sformatf("strobed_%0d", i), {24'b0, d}, 32'h01);
    end

    send_byte(8'h3C, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    check("frame_err_keep", {24'b0, rx_data_peek}, 32'hA5);
    bus_read(1'b0, d);
    check("frame_err_read", {24'b0, d}, 32'h01);

    send_byte(8'h3C, 1'b1);
    check("rx_3c", {24'b0, rx_data_peek}, 32'h3C);
    bus_read(1'b0, d);
    check("strobed_update", {24'b0, d}, 32'h00);

    bus_write(1'b0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      bus_read(1'b0, d);
      check($sformatf("read_3c_%0d", i), {24'b0, d},
            {31'b0, exp_3c[i]});
    end

    bus_read(1'b1, d);
    check("ctrl2_read", {24'b0, d}, 32'h00);
    bus_write(1'b1, 8'h01);
    bus_read(1'b0, d);
    check("ctrl2_write_ignored", {24'b0, d}, 32'h01);

    @(negedge clk);
    cs = 1'b1;
    rw = 1'b1;
    addr = 1'b0;
    #2;
    check("z_cs_high", {24'b0, cpubus}, 32'hFF);
    @(negedge clk);
    cs = 1'b0;
    rw = 1'b0;
    addr = 1'b1;
    #2;
    check("z_rw_low", {24'b0, cpubus}, 32'hFF);
    @(negedge clk);
    cs = 1'b1;
    rw = 1'b1;
    addr = 1'b0;
    check("txd_idle", {31'b0, txd}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nes_uart_controller.md
Name: nes_uart_controller

Overview:
- Emulates the NES standard joypad ports ($4016/$4017) for the CPU bus.
- Button state arrives from a host PC over a UART receive line (8N1). Each received byte is the full button vector.
- The CPU strobes and then serially reads the buttons exactly as it would a real NES shift-register controller.
- Contains an internal 16x-oversampling baud tick generator (baud_rate_gen) and a UART receiver.

Parameters:
- BAUD_DIV, 326, clock cycles per oversample tick (50 MHz / (9600 baud × 16)).
- OVERSAMPLE, 16, ticks per UART bit.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  chip select, active low.
- rw  input  1  1 = CPU read, 0 = CPU write.
- addr  input  1  0 = $4016 (controller 1), 1 = $4017 (controller 2).
- cpubus  inout  8  CPU data bus. Driven only during a selected read, else high-Z.
- rxd  input  1  UART receive line, idle high.
- txd  output  1  UART transmit line. Held constant 1 (idle); no transmit function.
- rx_data_peek  output  8  last valid received button byte (debug).

Behaviour:
- Reset: all state is cleared asynchronously on rst_n low.
  - Baud counter = 0, RX FSM = IDLE.
  - Button register = 8'h00, rx_data_peek = 8'h00.
  - Strobe = 0, shift register = 8'h00.
  - txd = 1, cpubus = Z.
- Baud generator:
  - Counter counts 0..BAUD_DIV-1 and wraps.
  - Emits a 1-cycle tick (en) when the counter wraps.
- RX FSM states are IDLE, START, DATA, STOP. All transitions are evaluated on tick cycles only.
  - rxd is double-flopped before use.
  - IDLE: when rxd is sampled 0, go to START and clear the tick count.
  - START: after 8 ticks, recheck rxd. If 0, go to DATA. If 1, treat as a glitch and return to IDLE.
  - DATA: sample every 16 ticks (mid-bit). Shift the sample in LSB-first, 8 bits, then go to STOP.
  - STOP: after 16 ticks, sample rxd.
    - If 1: load the button register with the assembled byte, then return to IDLE.
    - If 0 (framing error): discard the byte, keep the old button register, and wait in IDLE for rxd to return high before accepting a new start bit.
  - Reset mid-frame aborts the frame with no register update.
- Button bit mapping: bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right. 1 = pressed.
- rx_data_peek = button register, combinational.
- Access decode:
  - Write: cs=0, rw=0, addr=0. Strobe ← cpubus[0], registered each cycle the write is active.
  - Writes to addr=1 are ignored.
- Latching:
  - While strobe=1, the shift register reloads from the button register every cycle.
  - On strobe 1→0, the last loaded value is held.
- Read of addr=0 (cs=0, rw=1):
  - cpubus = {7'b0, shift[0]}, combinational.
  - While strobe=1, reads always return the current A bit.
- Read advance:
  - One shift per read access, performed on the cycle the read select deasserts (1→0 edge of the registered select). This makes the shift independent of access length.
  - On a shift, the shift register takes shift>>1 with a 1 entering bit7. Reads 9 and later return 1.
  - No shift occurs while strobe=1.
- Read of addr=1 (cs=0, rw=1): cpubus = 8'h00. This means controller 2 is not present.
- Simultaneous events:
  - A button register update during shifting does not affect the shift register until the next strobe.
  - A button register update and a strobe load in the same cycle: the load uses the old value; the new value is used next cycle.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 10 cycles.
  - Required: txd=1, rx_data_peek=00, cpubus=Z with cs=1.
  - After release: the en tick is spaced exactly BAUD_DIV cycles apart.
- UART receive:
  - Stimulus: send 0xA5 on rxd at 16 ticks/bit (start bit, LSB first, stop bit).
  - Required: rx_data_peek=A5 within 1 tick after the stop-bit sample.
- Framing error:
  - Stimulus: send 0x3C with the stop bit held 0.
  - Required: rx_data_peek remains A5. A following valid byte 0x3C is then accepted.
- Strobe and read (buttons = A5):
  - Stimulus: write 01 then 00 to addr 0, then perform 10 single-cycle reads.
  - Required: cpubus[0] = 1,0,1,0,0,1,0,1,1,1 and cpubus[7:1]=0.
- Reads while strobed:
  - Stimulus: strobe=1, 3 reads.
  - Required: every read returns 01. Changing rxd data mid-strobe is reflected within 1 cycle of the button update.
- Controller 2 and bus release:
  - Stimulus: read addr=1.
  - Required: 00. Write to addr=1 leaves the strobe unchanged. cs=1 or rw=0 leaves cpubus=Z.
